note_sequencer: RTL and testbench
=================================

# note_sequencer

Upstream control stage of the OrganSynth voice path. It buffers note events (pitch code plus duration in tempo ticks) from the score/host side and plays them back one at a time at a programmable tempo. For each note it drives the 7-bit address consumed by `fcw_table`, plus a gate strobe for the envelope/mixer. Pitch code 0 is silence, since the fcw lookup returns 0 for address 0.

## Interface
- `DEPTH`, default 8: event FIFO depth; power of two, ≥2.
- `ARTIC`, default 0: 1 = drop gate during the final tick of every note longer than 1 tick (articulation gap).
- `clk`, in, 1: single system clock.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `in_valid`, in, 1: note event offered.
- `in_ready`, out, 1: FIFO not full.
- `in_pitch`, in, 7: pitch code; 0x01–0x58 playable, 0 or >0x58 is a rest.
- `in_dur`, in, 8: duration in ticks; 0 means discard.
- `tick_period`, in, 24: clocks per tick; 0 is treated as 1; sampled every cycle.
- `run`, in, 1: 1 = play, 0 = pause.
- `clear`, in, 1: synchronous flush.
- `fcw_addr`, out, 7: address to `fcw_table`.
- `gate`, out, 1: note sounding.
- `note_start`, out, 1: one-cycle pulse on each note/rest load.
- `busy`, out, 1: state is PLAY.
- `fifo_count`, out, $clog2(DEPTH)+1: buffered events.

## Operation
- FIFO write on `in_valid && in_ready`. `in_ready = (fifo_count != DEPTH)` comes from registered count only and never depends on a same-cycle pop.
- FSM states are IDLE and PLAY. Registers: `dur_cnt` (8 bits) and `tick_cnt` (24 bits).
- Load, from IDLE with `run && fifo_count != 0`, or from the PLAY note end:
  - Pop the head.
  - If dur = 0: discard, state becomes IDLE, outputs are 0, no `note_start`.
  - Otherwise: `dur_cnt = dur`, `tick_cnt = 0`, `fcw_addr = playable ? pitch : 0`, `gate = playable`, `note_start = 1`, state becomes PLAY.
- In PLAY with `run = 1`, `tick_cnt` counts 0..P−1 (P = max(`tick_period`, 1)). The tick fires when `tick_cnt == P−1`; `tick_cnt` wraps to 0 and `dur_cnt` decrements.
- Note end is a tick with `dur_cnt == 1`:
  - If `run && fifo_count != 0`, load the next event on the same edge, gaplessly.
  - Otherwise go to IDLE with `fcw_addr = 0`, `gate = 0`.
- With `ARTIC = 1` and loaded dur > 1, `gate = 0` while `dur_cnt == 1`; `fcw_addr` is held.
- With `run = 0` in PLAY (pause): `tick_cnt` and `dur_cnt` freeze, `gate` is forced 0, `fcw_addr` is held. `gate` is restored on the cycle after `run` returns to 1.
- `clear` has highest priority over push, pop and play. It empties the FIFO, sets IDLE, and sets all outputs to 0. A push in the same cycle is dropped.
- A `tick_period` change takes effect immediately. If `tick_cnt ≥ P−1` after the change, the next cycle ticks.

## Timing
- Reset values: `fcw_addr` = 0, `gate` = 0, `note_start` = 0, `busy` = 0, `fifo_count` = 0, `in_ready` = 1, state = IDLE, all counters 0.
- Event accepted at edge E into an empty FIFO in IDLE with `run = 1`: outputs load at edge E+1. This is a 2-edge latency, visible after E+1.
- A note of duration D sounds for exactly D·P cycles from its load edge to its end edge, excluding pause time.
- Back-to-back notes have no silent cycle: `note_start` pulses on the end edge of the previous note.
- All outputs are registered. `in_ready` is the only combinational output, and it is derived from a register.

## Structure
- `organ_pkg` holds: `PITCH_W = 7`, `DUR_W = 8`, `TICK_W = 24`, `PITCH_MAX = 7'h58`, the state enum (`SEQ_IDLE`, `SEQ_PLAY`), and a packed event struct {pitch, dur}.
- Sub-module `seq_fifo`: synchronous FIFO, `DEPTH`×15 bits. It has push, pop, clear, count, and head data (first-word fall-through).
- The top level contains the FSM, tick counter and duration counter.

## Test plan
- P=4: push (0x31, 2) then (0x3C, 3) with `run = 1`.
  - `note_start` at E+1; `fcw_addr = 0x31` for 8 cycles, then `0x3C` for 12 cycles, with no gap.
  - Then `fcw_addr` = 0, `gate` = 0, `busy` = 0.
- Push 9 events with `run = 0` and `DEPTH = 8`: `in_ready` falls after the 8th, the 9th is held off, and `fifo_count = 8`.
- Events (0x00, 2), (0x60, 1), (0x20, 0), (0x40, 1) at P=1:
  - Two rests with `gate = 0`, `fcw_addr = 0`, 2 and 1 cycles.
  - The dur-0 event is discarded with no `note_start`.
  - Then `0x40` for 1 cycle.
- `ARTIC = 1`, P=3, (0x45, 3): `gate` is high for 6 cycles then low for 3 while `fcw_addr = 0x45`.
- Pause: drop `run` for 10 cycles mid-note. Total note length grows by exactly 10 cycles, and `gate` is low throughout the pause.
- Assert `clear`, and separately `rst_n`, mid-note with 3 events queued. On the next edge (or immediately for reset) all outputs are 0, `fifo_count = 0`, and nothing plays afterwards.

Source files
------------

// File: rtl/organ_pkg.sv
// rtl/organ_pkg.sv - shared widths, state encoding and note event type for the voice path
package organ_pkg;

   localparam int PITCH_W = 7;
   localparam int DUR_W   = 8;
   localparam int TICK_W  = 24;

   localparam logic [PITCH_W-1:0] PITCH_MAX = 7'h58;

   typedef enum logic {
      SEQ_IDLE,
      SEQ_PLAY
   } seq_state_t;

   typedef struct packed {
      logic [PITCH_W-1:0] pitch;
      logic [DUR_W-1:0]   dur;
   } note_evt_t;

   // Codes outside 0x01..PITCH_MAX are rests.
   function automatic logic is_playable(input logic [PITCH_W-1:0] p);
      return (p != '0) && (p <= PITCH_MAX);
   endfunction

endpackage

// File: rtl/seq_fifo.sv
// rtl/seq_fifo.sv - first-word fall-through event FIFO for the note sequencer
module seq_fifo
   import organ_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  note_evt_t                wdata,
   output note_evt_t                rdata,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   note_evt_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Guard against overflow/underflow locally so the FIFO stays consistent on its own.
   assign push_ok = push && !clear && (count != CW'(DEPTH));
   assign pop_ok  = pop  && !clear && (count != '0);
   assign rdata   = mem[rd_ptr];

   // Storage array; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; clear flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - buffers note events and plays them at a programmable tempo
module note_sequencer
   import organ_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ARTIC = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PITCH_W-1:0]       in_pitch,
   input  logic [DUR_W-1:0]         in_dur,
   input  logic [TICK_W-1:0]        tick_period,
   input  logic                     run,
   input  logic                     clear,
   output logic [PITCH_W-1:0]       fcw_addr,
   output logic                     gate,
   output logic                     note_start,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   seq_state_t          state;
   seq_state_t          state_n;
   logic [DUR_W-1:0]    dur_cnt;
   logic [DUR_W-1:0]    dur_n;
   logic [TICK_W-1:0]   tick_cnt;
   logic [TICK_W-1:0]   tick_n;
   logic [PITCH_W-1:0]  addr_n;
   logic                gate_n;
   logic                start_n;
   logic                sounding;
   logic                snd_n;
   logic                long_note;
   logic                long_n;
   logic                push;
   logic                pop;
   logic                load;
   logic                tick;
   logic [TICK_W-1:0]   period;
   note_evt_t           wdata;
   note_evt_t           head;

   // in_ready only looks at the registered count, never at a same-cycle pop.
   assign in_ready    = (fifo_count != CW'(DEPTH));
   assign push        = in_valid && in_ready && !clear;
   assign wdata.pitch = in_pitch;
   assign wdata.dur   = in_dur;
   assign busy        = (state == SEQ_PLAY);

   // A zero period behaves as one; ">=" makes a shortened period tick on the next cycle.
   assign period = (tick_period == '0) ? TICK_W'(1) : tick_period;
   assign tick   = (tick_cnt >= (period - TICK_W'(1)));

   seq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (head),
      .count (fifo_count)
   );

   // Next-state: idle/play sequencing, tick and duration counting, event loading.
   always_comb begin
      state_n = state;
      dur_n   = dur_cnt;
      tick_n  = tick_cnt;
      addr_n  = fcw_addr;
      snd_n   = sounding;
      long_n  = long_note;
      start_n = 1'b0;
      pop     = 1'b0;
      load    = 1'b0;
      gate_n  = 1'b0;

      if (clear) begin
         state_n = SEQ_IDLE;
         dur_n   = '0;
         tick_n  = '0;
         addr_n  = '0;
         snd_n   = 1'b0;
         long_n  = 1'b0;
      end else begin
         case (state)
            SEQ_IDLE: begin
               if (run && (fifo_count != '0)) load = 1'b1;
            end
            SEQ_PLAY: begin
               if (run) begin
                  if (tick) begin
                     tick_n = '0;
                     dur_n  = dur_cnt - DUR_W'(1);
                     if (dur_cnt == DUR_W'(1)) begin
                        if (fifo_count != '0) begin
                           load = 1'b1;
                        end else begin
                           state_n = SEQ_IDLE;
                           addr_n  = '0;
                           snd_n   = 1'b0;
                           long_n  = 1'b0;
                        end
                     end
                  end else begin
                     tick_n = tick_cnt + TICK_W'(1);
                  end
               end
            end
            default: state_n = SEQ_IDLE;
         endcase

         if (load) begin
            pop    = 1'b1;
            tick_n = '0;
            if (head.dur == '0) begin
               state_n = SEQ_IDLE;
               dur_n   = '0;
               addr_n  = '0;
               snd_n   = 1'b0;
               long_n  = 1'b0;
            end else begin
               state_n = SEQ_PLAY;
               dur_n   = head.dur;
               addr_n  = is_playable(head.pitch) ? head.pitch : '0;
               snd_n   = is_playable(head.pitch);
               long_n  = (head.dur > DUR_W'(1));
               start_n = 1'b1;
            end
         end
      end

      // Gate follows the sounding note, dropped while paused and in the articulation gap.
      gate_n = (state_n == SEQ_PLAY) && run && snd_n &&
               !((ARTIC != 0) && long_n && (dur_n == DUR_W'(1)));
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEQ_IDLE;
         dur_cnt    <= '0;
         tick_cnt   <= '0;
         fcw_addr   <= '0;
         gate       <= 1'b0;
         note_start <= 1'b0;
         sounding   <= 1'b0;
         long_note  <= 1'b0;
      end else begin
         state      <= state_n;
         dur_cnt    <= dur_n;
         tick_cnt   <= tick_n;
         fcw_addr   <= addr_n;
         gate       <= gate_n;
         note_start <= start_n;
         sounding   <= snd_n;
         long_note  <= long_n;
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer
module tb_note_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [6:0]  in_pitch;
   logic [7:0]  in_dur;
   logic [23:0] tick_period;
   logic        run;
   logic        clear;
   logic        in_ready, gate, note_start, busy;
   logic [6:0]  fcw_addr;
   logic [3:0]  fifo_count;
   logic        a_in_ready, a_gate, a_note_start, a_busy;
   logic [6:0]  a_fcw_addr;
   logic [3:0]  a_fifo_count;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   typedef struct {
      logic [6:0] addr;
      int gh;
      int gha;
      int act;
      int tot;
   } exp_t;
   exp_t exp_q[$];

   bit         mon_en  = 1'b1;
   bit         in_note = 1'b0;
   logic [6:0] cur_addr;
   int         n_tot, n_act, n_g, n_ga, addr_err;
   int         ns_cnt = 0;
   int         start_q[$];

   note_sequencer #(.DEPTH(8), .ARTIC(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pitch(in_pitch), .in_dur(in_dur), .tick_period(tick_period),
      .run(run), .clear(clear), .fcw_addr(fcw_addr), .gate(gate),
      .note_start(note_start), .busy(busy), .fifo_count(fifo_count)
   );

   note_sequencer #(.DEPTH(8), .ARTIC(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_pitch(in_pitch), .in_dur(in_dur), .tick_period(tick_period),
      .run(run), .clear(clear), .fcw_addr(a_fcw_addr), .gate(a_gate),
      .note_start(a_note_start), .busy(a_busy), .fifo_count(a_fifo_count)
   );

   initial forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit bench_playable(input logic [6:0] p);
      return (p >= 7'h01) && (p <= 7'h58);
   endfunction

   task automatic finish_note();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_note", 32'(cur_addr), 32'hffff_ffff);
      end else begin
         e = exp_q.pop_front();
         check("note_addr", 32'(cur_addr), 32'(e.addr));
         check("addr_stable", addr_err, 0);
         check("gate_cycles", n_g, e.gh);
         check("artic_gate_cycles", n_ga, e.gha);
         check("active_cycles", n_act, e.act);
         check("total_cycles", n_tot, e.tot);
      end
      in_note = 1'b0;
   endtask

   // Note monitor: measures each note between its load edge and its end edge.
   initial forever begin
      @(negedge clk);
      if (note_start) ns_cnt++;
      if (!rst_n || !mon_en) begin
         in_note = 1'b0;
      end else begin
         if (in_note && (note_start || !busy)) finish_note();
         if (note_start) begin
            in_note  = 1'b1;
            cur_addr = fcw_addr;
            n_tot = 0; n_act = 0; n_g = 0; n_ga = 0; addr_err = 0;
            start_q.push_back(cyc);
         end
         if (in_note) begin
            n_tot++;
            if (run)    n_act++;
            if (gate)   n_g++;
            if (a_gate) n_ga++;
            if (fcw_addr != cur_addr || a_fcw_addr != cur_addr) addr_err++;
         end
      end
   end

   task automatic push_evt(input logic [6:0] p, input logic [7:0] d, input bit expect_play, input int extra);
      int   per;
      int   guard;
      exp_t e;
      guard = 0;
      in_valid = 1'b1;
      in_pitch = p;
      in_dur   = d;
      while (!in_ready && guard < 100) begin
         step();
         guard++;
      end
      check("push_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      if (expect_play && d != 0) begin
         per   = (tick_period == 0) ? 1 : int'(tick_period);
         e.act = int'(d) * per;
         e.tot = e.act + extra;
         if (bench_playable(p)) begin
            e.addr = p;
            e.gh   = e.act;
            e.gha  = (d > 1) ? e.act - per : e.act;
         end else begin
            e.addr = 7'h00;
            e.gh   = 0;
            e.gha  = 0;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int max);
      int k;
      k = 0;
      while (!(!busy && fifo_count == 0 && exp_q.size() == 0 && !in_note) && k < max) begin
         step();
         k++;
      end
      check("drain_in_time", 32'(k < max), 32'd1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_addr"},  32'(fcw_addr),   32'd0);
      check({tag, "_gate"},  32'(gate),       32'd0);
      check({tag, "_start"}, 32'(note_start), 32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_count"}, 32'(fifo_count), 32'd0);
      check({tag, "_ready"}, 32'(in_ready),   32'd1);
   endtask

   initial begin
      int ns0;
      rst_n = 1'b0; in_valid = 1'b0; in_pitch = '0; in_dur = '0;
      tick_period = 24'd4; run = 1'b0; clear = 1'b0;
      repeat (3) step();
      check_quiet("reset_held");
      check("reset_a_addr",  32'(a_fcw_addr),   32'd0);
      check("reset_a_gate",  32'(a_gate),       32'd0);
      check("reset_a_start", 32'(a_note_start), 32'd0);
      check("reset_a_busy",  32'(a_busy),       32'd0);
      check("reset_a_count", 32'(a_fifo_count), 32'd0);
      check("reset_a_ready", 32'(a_in_ready),   32'd1);
      rst_n = 1'b1;
      step();
      check_quiet("reset_rel");

      // Two back-to-back notes at P=4, checking load latency and gapless handoff.
      run = 1'b1;
      start_q.delete();
      push_evt(7'h31, 8'd2, 1'b1, 0);
      check("lat_no_start_E", 32'(note_start), 32'd0);
      check("lat_idle_E",     32'(busy),       32'd0);
      push_evt(7'h3C, 8'd3, 1'b1, 0);
      check("lat_start_E1", 32'(note_start), 32'd1);
      check("lat_addr_E1",  32'(fcw_addr),   32'h31);
      check("lat_gate_E1",  32'(gate),       32'd1);
      wait_done(200);
      check("b2b_starts", start_q.size(), 2);
      if (start_q.size() == 2) check("b2b_gap", start_q[1] - start_q[0], 8);
      check_quiet("b2b_end");

      // Fill the FIFO while paused; the ninth event must be held off.
      run = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_pitch = 7'(i + 1); in_dur = 8'd1;
         check("fill_ready", 32'(in_ready), 32'd1);
         step();
      end
      check("full_count", 32'(fifo_count), 32'd8);
      check("full_ready", 32'(in_ready),   32'd0);
      in_pitch = 7'h09;
      repeat (3) step();
      check("full_held", 32'(fifo_count), 32'd8);
      in_valid = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check_quiet("full_clear");

      // Rests, discard and pitch range boundaries at P=1.
      tick_period = 24'd1;
      push_evt(7'h00, 8'd2, 1'b1, 0);
      push_evt(7'h60, 8'd1, 1'b1, 0);
      push_evt(7'h20, 8'd0, 1'b1, 0);
      push_evt(7'h40, 8'd1, 1'b1, 0);
      push_evt(7'h58, 8'd1, 1'b1, 0);
      push_evt(7'h59, 8'd1, 1'b1, 0);
      ns0 = ns_cnt;
      run = 1'b1;
      wait_done(100);
      check("rest_starts", ns_cnt - ns0, 5);

      // Articulation gap (checked on the ARTIC instance) at P=3.
      tick_period = 24'd3;
      push_evt(7'h45, 8'd3, 1'b1, 0);
      wait_done(100);

      // Zero period behaves as one.
      tick_period = 24'd0;
      push_evt(7'h22, 8'd3, 1'b1, 0);
      wait_done(100);

      // Pause mid-note for 10 cycles at P=5.
      tick_period = 24'd5;
      push_evt(7'h50, 8'd4, 1'b1, 10);
      repeat (3) step();
      run = 1'b0;
      repeat (2) step();
      check("pause_gate", 32'(gate),     32'd0);
      check("pause_addr", 32'(fcw_addr), 32'h50);
      check("pause_busy", 32'(busy),     32'd1);
      repeat (8) step();
      run = 1'b1;
      wait_done(200);

      // Clear mid-note with three events queued and a simultaneous push.
      mon_en = 1'b0;
      run = 1'b0;
      tick_period = 24'd2;
      for (int i = 0; i < 4; i++) push_evt(7'(8'h30 + i), 8'd5, 1'b0, 0);
      run = 1'b1;
      repeat (4) step();
      check("clr_pre_count", 32'(fifo_count), 32'd3);
      check("clr_pre_busy",  32'(busy),       32'd1);
      clear = 1'b1; in_valid = 1'b1; in_pitch = 7'h34; in_dur = 8'd2;
      step();
      clear = 1'b0; in_valid = 1'b0;
      check_quiet("clear");
      mon_en = 1'b1;
      ns0 = ns_cnt;
      repeat (40) step();
      check("clear_silent", ns_cnt - ns0, 0);
      check("clear_idle",   32'(busy),    32'd0);

      // Asynchronous reset mid-note with three events queued.
      mon_en = 1'b0;
      run = 1'b0;
      for (int i = 0; i < 4; i++) push_evt(7'(8'h40 + i), 8'd5, 1'b0, 0);
      run = 1'b1;
      repeat (4) step();
      check("rst_pre_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_quiet("async_rst");
      step();
      rst_n = 1'b1;
      mon_en = 1'b1;
      ns0 = ns_cnt;
      repeat (40) step();
      check("rst_silent", ns_cnt - ns0, 0);
      check("rst_idle",   32'(busy),    32'd0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
